// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle between the raster generator, the drawing objects/mux and the VGA DAC pins.
// Latency: none, wires only.
// Backpressure: none; the raster is free-running and every consumer must keep up with the pixel clock.
interface vga_timing_gen_if;
    // colour returned by the object mux
    logic [7:0]  redIn;
    logic [7:0]  greenIn;
    logic [7:0]  blueIn;
    // raster position broadcast to drawing objects
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    // DAC pins
    logic [7:0]  oVGA_R;
    logic [7:0]  oVGA_G;
    logic [7:0]  oVGA_B;
    logic        oVGA_HS;
    logic        oVGA_VS;
    logic        oVGA_BLANK_N;

    modport master (
        input  redIn, greenIn, blueIn,
        output pixelX, pixelY, startOfFrame,
        output oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS, oVGA_BLANK_N
    );

    modport slave (
        output redIn, greenIn, blueIn,
        input  pixelX, pixelY, startOfFrame,
        input  oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS, oVGA_BLANK_N
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster counters, pixel position broadcast, and DAC pin driver with sync/blank aligned to mux colour.
// Latency: pixelX/pixelY have none; pins show a pixel PIPE_LAT+1 clocks after its pixelX/pixelY.
// Backpressure: none; free-running at the pixel clock, the mux must return colour exactly PIPE_LAT clocks later.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE_LAT = 1
) (
    input  logic               clk,
    input  logic               resetN,
    vga_timing_gen_if.master   vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS      = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS      = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } tim_t;

    localparam tim_t TIM_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1};

    logic [10:0]          h_cnt_q, h_cnt_d;
    logic [10:0]          v_cnt_q, v_cnt_d;
    logic                 sof_q, sof_d;
    logic                 run_q, run_d;
    tim_t                 tim_raw;
    tim_t [PIPE_LAT:0]    dly_q, dly_d;
    logic [23:0]          rgb_q, rgb_d;

    // Raster counters. The first edge after reset parks at (0,0) so the frame starts with a visible startOfFrame.
    always_comb begin
        run_d   = 1'b1;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!run_q) begin
            h_cnt_d = 11'd0;
            v_cnt_d = 11'd0;
        end else if (h_cnt_q == H_LAST) begin
            h_cnt_d = 11'd0;
            v_cnt_d = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
        end else begin
            h_cnt_d = h_cnt_q + 11'd1;
        end
        // registered so it is high exactly while the counters read (0,0)
        sof_d = (h_cnt_d == 11'd0) && (v_cnt_d == 11'd0);
    end

    // Raw timing from the current counters; forced idle until the raster is running so nothing leaks out of reset.
    always_comb begin
        tim_raw        = TIM_IDLE;
        tim_raw.active = run_q && (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        tim_raw.hs     = !(run_q && (h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
        tim_raw.vs     = !(run_q && (v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
    end

    // Timing delay line matching the mux pipeline plus the colour capture register.
    always_comb begin
        dly_d    = dly_q;
        dly_d[0] = tim_raw;
        for (int i = 1; i <= PIPE_LAT; i++) begin
            dly_d[i] = dly_q[i-1];
        end
        rgb_d = {vga.redIn, vga.greenIn, vga.blueIn};
    end

    // State registers; delay stages reset to idle (inactive, syncs high).
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            h_cnt_q <= 11'd0;
            v_cnt_q <= 11'd0;
            sof_q   <= 1'b0;
            run_q   <= 1'b0;
            dly_q   <= {(PIPE_LAT+1){TIM_IDLE}};
            rgb_q   <= 24'h0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            sof_q   <= sof_d;
            run_q   <= run_d;
            dly_q   <= dly_d;
            rgb_q   <= rgb_d;
        end
    end

    assign vga.pixelX       = h_cnt_q;
    assign vga.pixelY       = v_cnt_q;
    assign vga.startOfFrame = sof_q;

    // Colour captured during blanking never reaches the pins.
    assign vga.oVGA_R       = dly_q[PIPE_LAT].active ? rgb_q[23:16] : 8'h00;
    assign vga.oVGA_G       = dly_q[PIPE_LAT].active ? rgb_q[15:8]  : 8'h00;
    assign vga.oVGA_B       = dly_q[PIPE_LAT].active ? rgb_q[7:0]   : 8'h00;
    assign vga.oVGA_HS      = dly_q[PIPE_LAT].hs;
    assign vga.oVGA_VS      = dly_q[PIPE_LAT].vs;
    assign vga.oVGA_BLANK_N = dly_q[PIPE_LAT].active;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default geometry at PIPE_LAT 1/0/3 plus a shrunken geometry for whole-frame counts.
// Latency: expected pin values are queued per pixel and compared PIPE_LAT+1 clocks later.
// Backpressure: none; mux models follow pixelX/pixelY with the declared latency.
module tb_vga_timing_gen;
    logic clk;
    logic resetN;
    int   n_tests = 0;
    int   n_fail  = 0;

    vga_timing_gen_if if_a ();
    vga_timing_gen_if if_z ();
    vga_timing_gen_if if_c ();
    vga_timing_gen_if if_s ();

    vga_timing_gen #(.PIPE_LAT(1)) u_a (.clk(clk), .resetN(resetN), .vga(if_a));
    vga_timing_gen #(.PIPE_LAT(0)) u_z (.clk(clk), .resetN(resetN), .vga(if_z));
    vga_timing_gen #(.PIPE_LAT(3)) u_c (.clk(clk), .resetN(resetN), .vga(if_c));
    vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
                     .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
                     .PIPE_LAT(1)) u_s (.clk(clk), .resetN(resetN), .vga(if_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mux models: red = x, green = y, blue = x^y, returned after each instance's latency.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            if_a.redIn <= 8'h0; if_a.greenIn <= 8'h0; if_a.blueIn <= 8'h0;
        end else begin
            if_a.redIn   <= if_a.pixelX[7:0];
            if_a.greenIn <= if_a.pixelY[7:0];
            if_a.blueIn  <= if_a.pixelX[7:0] ^ if_a.pixelY[7:0];
        end
    end

    assign if_z.redIn   = if_z.pixelX[7:0];
    assign if_z.greenIn = if_z.pixelY[7:0];
    assign if_z.blueIn  = if_z.pixelX[7:0] ^ if_z.pixelY[7:0];

    logic [23:0] c_d1, c_d2, c_d3;
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            c_d1 <= 24'h0; c_d2 <= 24'h0; c_d3 <= 24'h0;
        end else begin
            c_d1 <= {if_c.pixelX[7:0], if_c.pixelY[7:0], if_c.pixelX[7:0] ^ if_c.pixelY[7:0]};
            c_d2 <= c_d1;
            c_d3 <= c_d2;
        end
    end
    assign {if_c.redIn, if_c.greenIn, if_c.blueIn} = c_d3;

    assign if_s.redIn   = 8'hFF;
    assign if_s.greenIn = 8'hFF;
    assign if_s.blueIn  = 8'hFF;

    // Scoreboard: expected pin values for each pixel of the default geometry.
    typedef struct packed {
        logic       bn;
        logic       hs;
        logic       vs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } exp_t;

    localparam exp_t EXP_IDLE = '{bn: 1'b0, hs: 1'b1, vs: 1'b1, r: 8'h00, g: 8'h00, b: 8'h00};

    exp_t q_a[$];
    exp_t q_z[$];
    exp_t q_c[$];
    int   hm = 0;
    int   vm = 0;
    bit   fresh = 1'b1;

    function automatic exp_t model_px(input int h, input int v);
        exp_t e;
        logic act;
        act  = (h < 640) && (v < 480);
        e.bn = act;
        e.hs = !((h >= 656) && (h < 752));
        e.vs = !((v >= 490) && (v < 492));
        e.r  = act ? 8'(h) : 8'h00;
        e.g  = act ? 8'(v) : 8'h00;
        e.b  = act ? (8'(h) ^ 8'(v)) : 8'h00;
        return e;
    endfunction

    // Reference raster: restarts at (0,0) on the first edge after reset and pushes one expectation per clock.
    always @(negedge clk) begin
        exp_t e;
        if (!resetN) begin
            q_a.delete(); q_z.delete(); q_c.delete();
            for (int i = 0; i < 2; i++) q_a.push_back(EXP_IDLE);
            q_z.push_back(EXP_IDLE);
            for (int i = 0; i < 4; i++) q_c.push_back(EXP_IDLE);
            fresh = 1'b1;
            hm = 0;
            vm = 0;
        end else begin
            if (fresh) begin
                fresh = 1'b0;
            end else if (hm == 799) begin
                hm = 0;
                vm = (vm == 524) ? 0 : vm + 1;
            end else begin
                hm = hm + 1;
            end
            e = model_px(hm, vm);
            // keep each queue a fixed-depth delay line even when no task is consuming it
            if (q_a.size() > 2) q_a.delete(0);
            if (q_z.size() > 1) q_z.delete(0);
            if (q_c.size() > 4) q_c.delete(0);
            q_a.push_back(e);
            q_z.push_back(e);
            q_c.push_back(e);
        end
    end

    task automatic test_reset();
        logic [49:0] obs;
        logic [8:0]  syncs;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            obs = {if_a.pixelX, if_a.pixelY, if_a.startOfFrame, if_a.oVGA_R, if_a.oVGA_G, if_a.oVGA_B,
                   if_a.oVGA_HS, if_a.oVGA_VS, if_a.oVGA_BLANK_N};
            n_tests++;
            if (obs !== {11'd0, 11'd0, 1'b0, 24'h0, 3'b110}) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %h expected %h", c, obs, {11'd0, 11'd0, 1'b0, 24'h0, 3'b110});
            end
            syncs = {if_z.oVGA_HS, if_z.oVGA_VS, if_z.oVGA_BLANK_N, if_c.oVGA_HS, if_c.oVGA_VS, if_c.oVGA_BLANK_N,
                     if_s.oVGA_HS, if_s.oVGA_VS, if_s.oVGA_BLANK_N};
            n_tests++;
            if (syncs !== 9'b110_110_110) begin
                n_fail++;
                $display("FAIL reset_syncs cycle %0d: got %b expected 110110110", c, syncs);
            end
        end
        #2 resetN = 1'b1;
        @(negedge clk); #1;
        n_tests++;
        if ({if_a.pixelX, if_a.pixelY, if_a.startOfFrame} !== {11'd0, 11'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL first_cycle: got x=%0d y=%0d sof=%b expected x=0 y=0 sof=1",
                     if_a.pixelX, if_a.pixelY, if_a.startOfFrame);
        end
    endtask

    task automatic test_alignment(input int ncyc);
        exp_t        e;
        logic [26:0] obs;
        int          hs_low = 0;
        int          first_hs_h = -1;
        bit          got_first = 1'b0;
        bit          got_last = 1'b0;
        logic        prev_bn = 1'b0;
        logic [7:0]  prev_r = 8'h0;
        logic [7:0]  first_red = 8'h0;
        logic [7:0]  last_red = 8'h0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk); #1;
            n_tests++;
            if (if_a.pixelX !== 11'(hm) || if_a.pixelY !== 11'(vm) || if_a.startOfFrame !== ((hm == 0) && (vm == 0))) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL counters: got x=%0d y=%0d sof=%b expected x=%0d y=%0d",
                                          if_a.pixelX, if_a.pixelY, if_a.startOfFrame, hm, vm);
            end
            n_tests++;
            if (q_a.size() == 0) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL align_lat1: got no expectation queued, required one");
            end else begin
                e   = q_a.pop_front();
                obs = {if_a.oVGA_BLANK_N, if_a.oVGA_HS, if_a.oVGA_VS, if_a.oVGA_R, if_a.oVGA_G, if_a.oVGA_B};
                if (obs !== e) begin
                    n_fail++;
                    if (n_fail < 20) $display("FAIL align_lat1 at x=%0d y=%0d: got %h expected %h", hm, vm, obs, e);
                end
            end
            if (!if_a.oVGA_HS) begin
                hs_low++;
                if (first_hs_h < 0) first_hs_h = hm;
            end
            if (if_a.oVGA_BLANK_N && !prev_bn && !got_first) begin
                first_red = if_a.oVGA_R;
                got_first = 1'b1;
            end
            if (!if_a.oVGA_BLANK_N && prev_bn && !got_last) begin
                last_red = prev_r;
                got_last = 1'b1;
            end
            prev_bn = if_a.oVGA_BLANK_N;
            prev_r  = if_a.oVGA_R;
        end
        n_tests++;
        if (hs_low !== 96 * (ncyc / 800)) begin
            n_fail++;
            $display("FAIL hs_width: got %0d low clocks expected %0d", hs_low, 96 * (ncyc / 800));
        end
        n_tests++;
        if (first_hs_h !== 658) begin
            n_fail++;
            $display("FAIL hs_offset_lat1: got first low at x=%0d expected 658", first_hs_h);
        end
        n_tests++;
        if (!got_first || first_red !== 8'h00) begin
            n_fail++;
            $display("FAIL first_red: got %h (seen %0d) expected 00", first_red, got_first);
        end
        n_tests++;
        if (!got_last || last_red !== 8'h7F) begin
            n_fail++;
            $display("FAIL last_red: got %h (seen %0d) expected 7f", last_red, got_last);
        end
    endtask

    task automatic test_latency_sweep(input int ncyc);
        exp_t        e;
        logic [26:0] obs;
        int          hs_z = -1;
        int          hs_c = -1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk); #1;
            n_tests++;
            if (q_z.size() == 0) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL align_lat0: got no expectation queued, required one");
            end else begin
                e   = q_z.pop_front();
                obs = {if_z.oVGA_BLANK_N, if_z.oVGA_HS, if_z.oVGA_VS, if_z.oVGA_R, if_z.oVGA_G, if_z.oVGA_B};
                if (obs !== e) begin
                    n_fail++;
                    if (n_fail < 20) $display("FAIL align_lat0 at x=%0d y=%0d: got %h expected %h", hm, vm, obs, e);
                end
            end
            n_tests++;
            if (q_c.size() == 0) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL align_lat3: got no expectation queued, required one");
            end else begin
                e   = q_c.pop_front();
                obs = {if_c.oVGA_BLANK_N, if_c.oVGA_HS, if_c.oVGA_VS, if_c.oVGA_R, if_c.oVGA_G, if_c.oVGA_B};
                if (obs !== e) begin
                    n_fail++;
                    if (n_fail < 20) $display("FAIL align_lat3 at x=%0d y=%0d: got %h expected %h", hm, vm, obs, e);
                end
            end
            if (!if_z.oVGA_HS && hs_z < 0) hs_z = hm;
            if (!if_c.oVGA_HS && hs_c < 0) hs_c = hm;
        end
        n_tests++;
        if (hs_z !== 657) begin
            n_fail++;
            $display("FAIL hs_offset_lat0: got first low at x=%0d expected 657", hs_z);
        end
        n_tests++;
        if (hs_c !== 660) begin
            n_fail++;
            $display("FAIL hs_offset_lat3: got first low at x=%0d expected 660", hs_c);
        end
    endtask

    // Shrunken 25x15 raster: 16x8 visible, HS 4 clocks/line, VS 2 lines, 375 clocks/frame.
    task automatic test_blank_gating();
        int bn_cnt = 0, hs_cnt = 0, vs_cnt = 0, sof_cnt = 0, bad_rgb = 0;
        int last_sof = -1;
        logic [23:0] want;
        for (int c = 0; c < 750; c++) begin
            @(negedge clk); #1;
            if (if_s.oVGA_BLANK_N) bn_cnt++;
            if (!if_s.oVGA_HS) hs_cnt++;
            if (!if_s.oVGA_VS) vs_cnt++;
            want = if_s.oVGA_BLANK_N ? 24'hFFFFFF : 24'h000000;
            if ({if_s.oVGA_R, if_s.oVGA_G, if_s.oVGA_B} !== want) bad_rgb++;
            if (if_s.startOfFrame) begin
                sof_cnt++;
                if (last_sof >= 0) begin
                    n_tests++;
                    if (c - last_sof !== 375) begin
                        n_fail++;
                        $display("FAIL sof_period: got %0d clocks expected 375", c - last_sof);
                    end
                end
                last_sof = c;
            end
        end
        n_tests++;
        if (bn_cnt !== 256) begin n_fail++; $display("FAIL visible_count: got %0d expected 256", bn_cnt); end
        n_tests++;
        if (hs_cnt !== 120) begin n_fail++; $display("FAIL hs_count_small: got %0d expected 120", hs_cnt); end
        n_tests++;
        if (vs_cnt !== 100) begin n_fail++; $display("FAIL vs_count_small: got %0d expected 100", vs_cnt); end
        n_tests++;
        if (sof_cnt !== 2) begin n_fail++; $display("FAIL sof_count: got %0d expected 2", sof_cnt); end
        n_tests++;
        if (bad_rgb !== 0) begin n_fail++; $display("FAIL blank_gating: got %0d bad rgb clocks expected 0", bad_rgb); end
    endtask

    task automatic test_mid_frame_reset();
        bit          found = 1'b0;
        int          first_low = -1;
        int          vs_glitch = 0;
        exp_t        e;
        logic [26:0] obs;
        logic [49:0] rst_obs;
        for (int c = 0; c < 1000 && !found; c++) begin
            @(negedge clk); #1;
            if (if_a.pixelX == 11'd100 && if_a.pixelY != 11'd0) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL mid_reset_wait: got no x=100 within 1000 clocks, required one");
        end
        #2 resetN = 1'b0;
        #1;
        rst_obs = {if_a.pixelX, if_a.pixelY, if_a.startOfFrame, if_a.oVGA_R, if_a.oVGA_G, if_a.oVGA_B,
                   if_a.oVGA_HS, if_a.oVGA_VS, if_a.oVGA_BLANK_N};
        n_tests++;
        if (rst_obs !== {11'd0, 11'd0, 1'b0, 24'h0, 3'b110}) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", rst_obs, {11'd0, 11'd0, 1'b0, 24'h0, 3'b110});
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_tests++;
            if ({if_a.oVGA_HS, if_a.oVGA_VS, if_a.oVGA_BLANK_N, if_a.pixelX} !== {3'b110, 11'd0}) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: got hs=%b vs=%b bn=%b x=%0d expected 1 1 0 0",
                         c, if_a.oVGA_HS, if_a.oVGA_VS, if_a.oVGA_BLANK_N, if_a.pixelX);
            end
        end
        #1 resetN = 1'b1;
        for (int c = 0; c < 700; c++) begin
            @(negedge clk); #1;
            if (c == 0) begin
                n_tests++;
                if ({if_a.pixelX, if_a.pixelY, if_a.startOfFrame} !== {11'd0, 11'd0, 1'b1}) begin
                    n_fail++;
                    $display("FAIL restart: got x=%0d y=%0d sof=%b expected 0 0 1",
                             if_a.pixelX, if_a.pixelY, if_a.startOfFrame);
                end
            end
            if (!if_a.oVGA_HS && first_low < 0) first_low = c;
            if (!if_a.oVGA_VS) vs_glitch++;
            n_tests++;
            if (q_a.size() == 0) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL post_reset_align: got no expectation queued, required one");
            end else begin
                e   = q_a.pop_front();
                obs = {if_a.oVGA_BLANK_N, if_a.oVGA_HS, if_a.oVGA_VS, if_a.oVGA_R, if_a.oVGA_G, if_a.oVGA_B};
                if (obs !== e) begin
                    n_fail++;
                    if (n_fail < 20) $display("FAIL post_reset_align at x=%0d: got %h expected %h", hm, obs, e);
                end
            end
        end
        n_tests++;
        if (first_low !== 658) begin
            n_fail++;
            $display("FAIL post_reset_hs: got first low %0d clocks after restart expected 658", first_low);
        end
        n_tests++;
        if (vs_glitch !== 0) begin
            n_fail++;
            $display("FAIL post_reset_vs: got %0d low clocks expected 0", vs_glitch);
        end
    endtask

    initial begin
        resetN = 1'b1;
        #1 resetN = 1'b0;
        test_reset();
        test_alignment(1600);
        test_latency_sweep(1000);
        test_blank_gating();
        test_mid_frame_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
